// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - issue/sequencing stage for the multi-cycle mult/div units
// Launches an op, counts the unit's fixed latency, then captures its result into HI/LO.
module muldiv_ctrl #(
  parameter int MULT_LAT = 35,
  parameter int DIV_LAT  = 34,
  parameter int CNT_W    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_op,
  input  logic [31:0] i_rs_val,
  input  logic [31:0] i_rt_val,
  input  logic        i_cancel,
  input  logic        i_mthi,
  input  logic        i_mtlo,
  input  logic [31:0] i_mt_data,
  output logic [31:0] o_unit_a,
  output logic [31:0] o_unit_b,
  output logic        o_mult_init,
  output logic        o_div_init,
  output logic        o_unit_stop,
  input  logic [31:0] i_mult_hi,
  input  logic [31:0] i_mult_lo,
  input  logic [31:0] i_div_hi,
  input  logic [31:0] i_div_lo,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_div_zero
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE, S_DZERO} state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

  state_t           r_state, w_next;
  logic             r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_unit_a, r_unit_b, r_hi, r_lo;
  logic             r_mult_init, r_div_init, r_unit_stop, r_busy, r_done, r_div_zero;

  logic w_dz, w_launch, w_cancel, w_capture;
  logic w_mult_init_d, w_div_init_d, w_unit_stop_d, w_busy_d, w_done_d, w_div_zero_d;

  assign w_dz      = (r_state == S_IDLE) && i_start && i_op && (i_rt_val == '0);
  assign w_launch  = (r_state == S_IDLE) && i_start && !w_dz;
  assign w_cancel  = i_cancel && ((r_state == S_LAUNCH) || (r_state == S_WAIT));
  assign w_capture = (r_state == S_WAIT) && !i_cancel && (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_dz)         w_next = S_DZERO;
        else if (i_start) w_next = S_LAUNCH;
      end
      S_LAUNCH: w_next = i_cancel ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (i_cancel)           w_next = S_IDLE;
        else if (r_cnt == '0)   w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      S_DZERO: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Pulse values for the coming cycle; registered below so every output is a flop.
  always_comb begin
    w_mult_init_d = w_launch && !i_op;
    w_div_init_d  = w_launch && i_op;
    w_unit_stop_d = w_cancel;
    w_busy_d      = (w_next != S_IDLE);
    w_done_d      = w_capture || w_dz;
    w_div_zero_d  = w_dz;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op        <= 1'b0;
      r_cnt       <= '0;
      r_unit_a    <= '0;
      r_unit_b    <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_mult_init <= 1'b0;
      r_div_init  <= 1'b0;
      r_unit_stop <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
    end else begin
      r_mult_init <= w_mult_init_d;
      r_div_init  <= w_div_init_d;
      r_unit_stop <= w_unit_stop_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
      r_div_zero  <= w_div_zero_d;
      if (w_launch) begin
        r_op     <= i_op;
        r_unit_a <= i_rs_val;
        r_unit_b <= i_rt_val;
      end
      if (r_state == S_LAUNCH)
        r_cnt <= r_op ? DIV_LOAD : MULT_LOAD;
      else if ((r_state == S_WAIT) && (r_cnt != '0))
        r_cnt <= r_cnt - CNT_W'(1);
      // Capture and MTHI/MTLO never coincide: one needs WAIT, the other IDLE.
      if (w_capture) begin
        r_hi <= r_op ? i_div_hi : i_mult_hi;
        r_lo <= r_op ? i_div_lo : i_mult_lo;
      end else if (r_state == S_IDLE) begin
        if (i_mthi) r_hi <= i_mt_data;
        if (i_mtlo) r_lo <= i_mt_data;
      end
    end
  end

  assign o_unit_a    = r_unit_a;
  assign o_unit_b    = r_unit_b;
  assign o_mult_init = r_mult_init;
  assign o_div_init  = r_div_init;
  assign o_unit_stop = r_unit_stop;
  assign o_hi        = r_hi;
  assign o_lo        = r_lo;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_div_zero  = r_div_zero;

endmodule
